wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles (2..256) spent in LD_WAIT before declaring a bus error.
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: resetb  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: ex_valid  input  1  execute stage presents an instruction result.
REQ-005 SHALL have port: ex_ready  output  1  unit accepts the presented result this cycle.
REQ-006 SHALL have port: ex_rd  input  5  destination register index.
REQ-007 SHALL have port: ex_is_load  input  1  result comes from memory, not the ALU.
REQ-008 SHALL have port: ex_funct3  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-009 SHALL have port: ex_addr_lo  input  2  byte address bits [1:0] of the load.
REQ-010 SHALL have port: ex_alu  input  32  ALU result.
REQ-011 SHALL have port: mem_rvalid  input  1  load data valid strobe.
REQ-012 SHALL have port: mem_rdata  input  32  raw aligned 32-bit memory word.
REQ-013 SHALL have port: a_rd  output  5  register-file write address.
REQ-014 SHALL have port: d_rd  output  32  register-file write data.
REQ-015 SHALL have port: we_rd  output  1  register-file write enable.
REQ-016 SHALL have port: ld_pending  output  1  a load is outstanding (state LD_WAIT).
REQ-017 SHALL have port: ld_rd  output  5  destination of the outstanding load, for decode hazard stall.
REQ-018 SHALL have port: err  output  1  sticky fault flag.

Function
REQ-019 SHALL implement states IDLE, ALU_WB, LD_WAIT, LD_WB, ERR.
REQ-020 SHALL drive ex_ready=1 in IDLE, ALU_WB and LD_WB, and ex_ready=0 in LD_WAIT and ERR.
REQ-021 Accept = ex_valid && ex_ready; with no accept, the next state from IDLE/ALU_WB/LD_WB SHALL be IDLE.
REQ-022 On accepted ALU op: latch ex_rd/ex_alu; next state ALU_WB.
REQ-023 On accepted load with legal funct3 and alignment: latch ex_rd/funct3/addr_lo; clear timeout counter; next state LD_WAIT.
REQ-024 Illegal funct3 (011, 110, 111), LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0 SHALL go directly to ERR; no write occurs.
REQ-025 LD_WAIT with mem_rvalid=1: format mem_rdata, latch it, next state LD_WB (latency of 1 cycle from rvalid to we_rd).
REQ-026 LD_WAIT without rvalid: counter increments; when counter reaches TIMEOUT-1 without rvalid, next state SHALL be ERR.
REQ-027 LB/LBU SHALL select byte addr_lo (byte 0 = bits [7:0]); LH/LHU SHALL select half addr_lo[1]; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-028 In ALU_WB and LD_WB: a_rd=latched rd, d_rd=latched data, and we_rd=1 unless the latched rd==0, in which case we_rd=0.
REQ-029 In all other states, we_rd SHALL be 0; a_rd/d_rd hold their last values.
REQ-030 Back-to-back accepts SHALL yield one write per cycle with no bubble; an accept in LD_WB overlaps the load write.
REQ-031 mem_rvalid outside LD_WAIT SHALL be ignored.
REQ-032 ld_pending=1 exactly in LD_WAIT; ld_rd=latched rd (the value is held outside LD_WAIT).
REQ-033 ERR SHALL be terminal: err=1 and ex_ready=0 until reset.

Reset
REQ-034 resetb=0 at a clock edge SHALL force state IDLE, we_rd=0, err=0, ld_pending=0, a_rd=0, d_rd=0, ld_rd=0, counter=0, from any state including mid-load.
REQ-035 A mem_rvalid arriving in the same cycle as reset, or after reset, SHALL produce no write.

Verification
REQ-036 ALU op: rd=5, alu=0xDEADBEEF accepted -> next cycle we_rd=1, a_rd=5, d_rd=0xDEADBEEF.
REQ-037 LB: rd=3, addr_lo=2, rdata=0x0080_0000 returned after 4 cycles -> one cycle later we_rd=1, d_rd=0xFFFFFF80; ld_pending=1 for exactly 4 cycles; LBU with the same inputs -> d_rd=0x00000080.
REQ-038 ALU op with rd=0 -> we_rd stays 0; three back-to-back ALU ops (rd 1,2,3) -> writes on three consecutive cycles.
REQ-039 LW with no rvalid, TIMEOUT=16 -> ERR entered after 16 LD_WAIT cycles; err=1 and ex_ready=0 persist until resetb=0.
REQ-040 LH with addr_lo=1 -> ERR next cycle with no write; reset asserted mid-LD_WAIT, then rvalid -> no write, state IDLE.

Source files
------------

// File: rtl/wb_unit.sv
// Writeback unit: retires ALU results and formatted load data to the register
// file. It tracks one outstanding load with a timeout. Any malformed load or
// timeout latches a sticky error, and only reset clears it.
module wb_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic [31:0] ex_alu,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  a_rd,
  output logic [31:0] d_rd,
  output logic        we_rd,
  output logic        ld_pending,
  output logic [4:0]  ld_rd,
  output logic        err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ALU_WB, LD_WAIT, LD_WB, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    lf3;
  logic [1:0]    lalo;
  logic          ld_legal;
  logic [31:0]   ld_data;

  // Select and extend the addressed byte or halfword from the raw memory word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'b0, b};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // A load is legal only for a known funct3 at a naturally aligned address.
  always_comb begin
    ld_legal = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: ld_legal = 1'b1;
      3'b001, 3'b101: ld_legal = ~ex_addr_lo[0];
      3'b010:         ld_legal = (ex_addr_lo == 2'b00);
      default:        ld_legal = 1'b0;
    endcase
    ld_data = fmt_load(lf3, lalo, mem_rdata);
  end

  // Control FSM. The outputs are registered alongside the state, so each transition sets them for the state it enters.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= IDLE;
      ex_ready   <= 1'b1;
      we_rd      <= 1'b0;
      err        <= 1'b0;
      ld_pending <= 1'b0;
      a_rd       <= '0;
      d_rd       <= '0;
      ld_rd      <= '0;
      cnt        <= '0;
      lf3        <= '0;
      lalo       <= '0;
    end else begin
      we_rd <= 1'b0;
      case (state)
        IDLE, ALU_WB, LD_WB: begin
          if (ex_valid) begin
            if (!ex_is_load) begin
              state <= ALU_WB;
              a_rd  <= ex_rd;
              d_rd  <= ex_alu;
              we_rd <= (ex_rd != 5'd0);
            end else if (ld_legal) begin
              state      <= LD_WAIT;
              ld_rd      <= ex_rd;
              lf3        <= ex_funct3;
              lalo       <= ex_addr_lo;
              cnt        <= '0;
              ex_ready   <= 1'b0;
              ld_pending <= 1'b1;
            end else begin
              state    <= ERR;
              ex_ready <= 1'b0;
              err      <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        LD_WAIT: begin
          if (mem_rvalid) begin
            state      <= LD_WB;
            a_rd       <= ld_rd;
            d_rd       <= ld_data;
            we_rd      <= (ld_rd != 5'd0);
            ex_ready   <= 1'b1;
            ld_pending <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state      <= ERR;
            ld_pending <= 1'b0;
            err        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= ERR;
          ex_ready <= 1'b0;
          err      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed load/ALU/error/reset scenarios. A cycle-level
// behavioural model is compared every cycle, and literal expectations pin the key results.
module tb_wb_unit;

  localparam int TIMEOUT = 16;

  logic        clk, resetb;
  logic        ex_valid, ex_ready, ex_is_load;
  logic [4:0]  ex_rd, a_rd, ld_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_alu, mem_rdata, d_rd;
  logic        mem_rvalid, we_rd, ld_pending, err;

  wb_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetb(resetb), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
    .ex_addr_lo(ex_addr_lo), .ex_alu(ex_alu), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .a_rd(a_rd), .d_rd(d_rd), .we_rd(we_rd),
    .ld_pending(ld_pending), .ld_rd(ld_rd), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, pend_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend, m_err, m_we;
  logic [4:0]  m_a, m_ld_rd;
  logic [31:0] m_d;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  int          m_wait;

  function automatic bit legal(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return (lo % 2) == 0;
    if (f3 == 3'd2) return lo == 0;
    return 0;
  endfunction

  function automatic logic [31:0] shape(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic [31:0] w);
    logic [31:0] s;
    logic [7:0]  b;
    logic [15:0] h;
    s = w >> (8 * int'(lo));
    b = s[7:0];
    h = s[15:0];
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return 32'(b);
      3'd1:    return 32'($signed(h));
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetb) begin
      m_pend = 0; m_err = 0; m_we = 0; m_a = 0; m_d = 0; m_ld_rd = 0; m_wait = 0;
    end else begin
      m_we = 0;
      if (m_err) begin
        // sticky
      end else if (m_pend) begin
        if (mem_rvalid) begin
          m_pend = 0; m_a = m_ld_rd; m_d = shape(m_f3, m_lo, mem_rdata); m_we = (m_ld_rd != 0);
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin m_pend = 0; m_err = 1; end
        end
      end else if (ex_valid) begin
        if (!ex_is_load) begin
          m_a = ex_rd; m_d = ex_alu; m_we = (ex_rd != 0);
        end else if (legal(ex_funct3, ex_addr_lo)) begin
          m_pend = 1; m_wait = 0; m_ld_rd = ex_rd; m_f3 = ex_funct3; m_lo = ex_addr_lo;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (ld_pending === 1'b1) pend_cnt++;
    if (chk_en) begin
      chk("ex_ready", 32'(ex_ready), 32'(!m_pend && !m_err));
      chk("we_rd", 32'(we_rd), 32'(m_we));
      chk("a_rd", 32'(a_rd), 32'(m_a));
      chk("d_rd", d_rd, m_d);
      chk("ld_pending", 32'(ld_pending), 32'(m_pend));
      chk("ld_rd", 32'(ld_rd), 32'(m_ld_rd));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit ld, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] alu);
    ex_valid = 1; ex_is_load = ld; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = lo; ex_alu = alu;
    tick();
    ex_valid = 0;
  endtask

  task automatic do_reset();
    resetb = 0; tick(); tick(); resetb = 1;
  endtask

  // Load with data returned in the 4th wait cycle; checks the write one cycle later.
  task automatic load4(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] w, input logic [31:0] exp);
    pend_cnt = 0;
    issue(1, rd, f3, lo, 0);
    repeat (3) tick();
    mem_rvalid = 1; mem_rdata = w;
    tick();
    mem_rvalid = 0;
    chk({nm, "_we"}, 32'(we_rd), 32'(rd != 0));
    chk({nm, "_a"}, 32'(a_rd), 32'(rd));
    chk({nm, "_d"}, d_rd, exp);
    chk({nm, "_pend4"}, pend_cnt, 4);
  endtask

  initial begin
    resetb = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_funct3 = 0; ex_addr_lo = 0;
    ex_alu = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); chk_en = 1;
    tick(); resetb = 1;
    chk("rst_ready", 32'(ex_ready), 1);
    chk("rst_we", 32'(we_rd), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_d", d_rd, 0);

    // ALU op
    issue(0, 5, 0, 0, 32'hDEADBEEF);
    chk("alu_we", 32'(we_rd), 1);
    chk("alu_a", 32'(a_rd), 5);
    chk("alu_d", d_rd, 32'hDEADBEEF);
    tick();
    chk("alu_one_write", 32'(we_rd), 0);

    // stray rvalid in IDLE is ignored
    mem_rvalid = 1; mem_rdata = 32'h55; tick(); mem_rvalid = 0;
    chk("stray_rvalid", 32'(we_rd), 0);

    // loads
    load4("lb",  3,  3'b000, 2, 32'h0080_0000, 32'hFFFFFF80);
    load4("lbu", 3,  3'b100, 2, 32'h0080_0000, 32'h00000080);
    load4("lh",  7,  3'b001, 2, 32'h8001_1234, 32'hFFFF8001);
    load4("lhu", 8,  3'b101, 0, 32'h0000_F00F, 32'h0000F00F);
    load4("lw",  9,  3'b010, 0, 32'h1234_5678, 32'h12345678);
    load4("lb3", 4,  3'b000, 3, 32'h7F00_0000, 32'h0000007F);

    // rd=0 never writes
    issue(0, 0, 0, 0, 32'h1111);
    chk("rd0_we", 32'(we_rd), 0);

    // three back-to-back ALU ops
    ex_valid = 1; ex_is_load = 0;
    for (int i = 1; i <= 3; i++) begin
      ex_rd = 5'(i); ex_alu = 32'(i * 32'h100);
      tick();
      chk("b2b_we", 32'(we_rd), 1);
      chk("b2b_a", 32'(a_rd), 32'(i));
    end
    ex_valid = 0; tick();

    // load followed by ALU op held throughout; accepted in LD_WB overlapping the load write
    issue(1, 10, 3'b010, 0, 0);
    ex_valid = 1; ex_is_load = 0; ex_rd = 11; ex_alu = 32'hA5A5;
    tick();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; tick(); mem_rvalid = 0;
    chk("ovl_ld_a", 32'(a_rd), 10);
    chk("ovl_ld_d", d_rd, 32'hCAFEF00D);
    tick(); ex_valid = 0;
    chk("ovl_alu_a", 32'(a_rd), 11);
    chk("ovl_alu_we", 32'(we_rd), 1);
    tick();

    // reset mid LD_WAIT, rvalid coincident with and after reset
    issue(1, 12, 3'b010, 0, 0);
    tick();
    resetb = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    resetb = 1;
    chk("midrst_pend", 32'(ld_pending), 0);
    tick(); mem_rvalid = 0;
    chk("midrst_we", 32'(we_rd), 0);
    chk("midrst_ready", 32'(ex_ready), 1);
    chk("midrst_ld_rd", 32'(ld_rd), 0);

    // misaligned LH -> ERR next cycle, no write, sticky
    issue(1, 6, 3'b001, 1, 0);
    chk("lh_mis_err", 32'(err), 1);
    chk("lh_mis_we", 32'(we_rd), 0);
    chk("lh_mis_ready", 32'(ex_ready), 0);
    issue(0, 7, 0, 0, 32'h77);
    chk("err_no_accept", 32'(we_rd), 0);
    do_reset();
    chk("err_cleared", 32'(err), 0);

    // illegal funct3
    issue(1, 6, 3'b011, 0, 0);
    chk("f3_ill_err", 32'(err), 1);
    do_reset();

    // LW timeout
    pend_cnt = 0;
    issue(1, 13, 3'b010, 0, 0);
    for (int i = 0; i < 100 && err !== 1'b1; i++) tick();
    chk("to_err", 32'(err), 1);
    chk("to_cycles", pend_cnt, TIMEOUT);
    mem_rvalid = 1; repeat (5) tick(); mem_rvalid = 0;
    chk("to_sticky_err", 32'(err), 1);
    chk("to_sticky_ready", 32'(ex_ready), 0);
    chk("to_no_we", 32'(we_rd), 0);
    do_reset();
    chk("to_reset_err", 32'(err), 0);
    chk("to_reset_ready", 32'(ex_ready), 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
